// File: rtl/keypad_debouncer.sv
// keypad_debouncer: debounces scanner detections, emits one hex code per physical press, suppresses repeat until release.
// Latency: key_strobe/key_valid registered DEBOUNCE_CYCLES clocks after the key_pressed rise; other key_valid pulses one clock after the deciding cycle.
// Backpressure: none toward display; key_valid is the handshake that releases the scanner's held row, one pulse per rise.
// Ports: clk, rst_n | key_pressed, row_idx, col_idx (from scanner, one-hot indices)
//        key_valid (to scanner) | key_strobe, key_code, key_held (to display / key history)
module keypad_debouncer #(
   parameter int DEBOUNCE_CYCLES = 60000,
   parameter int RELEASE_CYCLES  = 30000,
   parameter int CNT_W           = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_pressed,
   input  logic [3:0] row_idx,
   input  logic [3:0] col_idx,
   output logic       key_valid,
   output logic       key_strobe,
   output logic [3:0] key_code,
   output logic       key_held
);

   typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD} state_t;

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state;
   logic             kp_d;
   logic [3:0]       cap_row;
   logic [3:0]       cap_col;
   logic [CNT_W-1:0] deb_cnt;
   logic [CNT_W-1:0] rel_cnt;
   logic             rise;
   logic             match;
   logic             idx_ok;

   function automatic logic is_onehot(input logic [3:0] v);
      return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
   endfunction

   function automatic logic [1:0] idx_of(input logic [3:0] v);
      case (v)
         4'b0010: return 2'd1;
         4'b0100: return 2'd2;
         4'b1000: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   // Physical keypad layout: rows 1-2-3-A / 4-5-6-B / 7-8-9-C / E-0-F-D
   function automatic logic [3:0] decode(input logic [3:0] r, input logic [3:0] c);
      case ({idx_of(r), idx_of(c)})
         4'h0: return 4'h1;  4'h1: return 4'h2;  4'h2: return 4'h3;  4'h3: return 4'hA;
         4'h4: return 4'h4;  4'h5: return 4'h5;  4'h6: return 4'h6;  4'h7: return 4'hB;
         4'h8: return 4'h7;  4'h9: return 4'h8;  4'hA: return 4'h9;  4'hB: return 4'hC;
         4'hC: return 4'hE;  4'hD: return 4'h0;  4'hE: return 4'hF;  default: return 4'hD;
      endcase
   endfunction

   // Only a fresh rise counts as a detection; the scanner may leave key_pressed
   // high for a cycle after key_valid and that must not be seen as a new press.
   assign rise   = key_pressed & ~kp_d;
   assign match  = key_pressed & (row_idx == cap_row) & (col_idx == cap_col);
   assign idx_ok = is_onehot(row_idx) & is_onehot(col_idx);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         kp_d       <= 1'b0;
         cap_row    <= 4'b0000;
         cap_col    <= 4'b0000;
         deb_cnt    <= '0;
         rel_cnt    <= '0;
         key_valid  <= 1'b0;
         key_strobe <= 1'b0;
         key_code   <= 4'h0;
         key_held   <= 1'b0;
      end else begin
         kp_d       <= key_pressed;
         key_valid  <= 1'b0;
         key_strobe <= 1'b0;
         case (state)
            IDLE: begin
               if (rise) begin
                  if (idx_ok) begin
                     cap_row <= row_idx;
                     cap_col <= col_idx;
                     deb_cnt <= '0;
                     state   <= DEBOUNCE;
                  end else begin
                     // Garbage indices: hand the row back to the scanner at once
                     key_valid <= 1'b1;
                  end
               end
            end
            DEBOUNCE: begin
               if (!match) begin
                  key_valid <= 1'b1;
                  state     <= IDLE;
               end else if (deb_cnt == DEB_LAST) begin
                  key_valid  <= 1'b1;
                  key_strobe <= 1'b1;
                  key_code   <= decode(cap_row, cap_col);
                  key_held   <= 1'b1;
                  rel_cnt    <= '0;
                  state      <= HELD;
               end else if (deb_cnt != CNT_MAX) begin
                  deb_cnt <= deb_cnt + CNT_ONE;
               end
            end
            HELD: begin
               if (rel_cnt != CNT_MAX)
                  rel_cnt <= rel_cnt + CNT_ONE;
               if (rise)
                  key_valid <= 1'b1;
               // A matching re-detection is the same key still down: restart the
               // release window. It wins over a timeout in the same cycle.
               if (rise && match) begin
                  rel_cnt <= '0;
               end else if ((rise && !idx_ok) || (rel_cnt == REL_LAST)) begin
                  key_held <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_debouncer.sv
module tb_keypad_debouncer;
   localparam int D = 8;
   localparam int R = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_pressed = 1'b0;
   logic [3:0] row_idx = 4'b0000;
   logic [3:0] col_idx = 4'b0000;
   logic       key_valid;
   logic       key_strobe;
   logic [3:0] key_code;
   logic       key_held;

   keypad_debouncer #(.DEBOUNCE_CYCLES(D), .RELEASE_CYCLES(R), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .key_pressed(key_pressed), .row_idx(row_idx), .col_idx(col_idx),
      .key_valid(key_valid), .key_strobe(key_strobe), .key_code(key_code), .key_held(key_held)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int n_valids = 0;
   int n_strobes = 0;

   // Reference model: press/release judged from cycle timestamps
   typedef enum {M_IDLE, M_DEB, M_HELD} mstate_t;
   mstate_t    m_st;
   bit         m_prev_kp;
   logic [3:0] m_row, m_col;
   int         cyc = 0;
   int         t_start, t_refresh;
   bit         e_valid, e_strobe, e_held;
   logic [3:0] e_code;
   logic [3:0] lut [16];

   typedef struct {
      logic [3:0] row;
      logic [3:0] col;
      bit         ok;
      logic [3:0] code;
   } vec_t;
   vec_t vec [19];

   function automatic bit onehot(input logic [3:0] v);
      return (v == 4'b0001) || (v == 4'b0010) || (v == 4'b0100) || (v == 4'b1000);
   endfunction

   function automatic int pos(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return 0;
   endfunction

   function automatic logic [3:0] oh(input int i);
      logic [3:0] v;
      v = 4'b0000;
      v[i] = 1'b1;
      return v;
   endfunction

   task automatic model_reset();
      m_st = M_IDLE; m_prev_kp = 1'b0; m_row = 4'b0000; m_col = 4'b0000;
      e_valid = 1'b0; e_strobe = 1'b0; e_held = 1'b0; e_code = 4'h0;
   endtask

   task automatic model_clock(input bit kp, input logic [3:0] r, input logic [3:0] c);
      bit rise, match;
      rise  = kp && !m_prev_kp;
      match = kp && (r == m_row) && (c == m_col);
      e_valid = 1'b0; e_strobe = 1'b0;
      case (m_st)
         M_IDLE: if (rise) begin
            if (onehot(r) && onehot(c)) begin
               m_row = r; m_col = c; t_start = cyc; m_st = M_DEB;
            end else e_valid = 1'b1;
         end
         M_DEB: if (!match) begin
            e_valid = 1'b1; m_st = M_IDLE;
         end else if (cyc - t_start == D) begin
            e_valid = 1'b1; e_strobe = 1'b1; e_held = 1'b1;
            e_code = lut[pos(m_row)*4 + pos(m_col)];
            t_refresh = cyc; m_st = M_HELD;
         end
         M_HELD: begin
            if (rise) e_valid = 1'b1;
            if (rise && match) t_refresh = cyc;
            else if ((rise && !(onehot(r) && onehot(c))) || (cyc - t_refresh == R)) begin
               e_held = 1'b0; m_st = M_IDLE;
            end
         end
         default: m_st = M_IDLE;
      endcase
      m_prev_kp = kp;
      cyc++;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, advance the model on the same edge, compare just after it
   task automatic step(input bit kp, input logic [3:0] r, input logic [3:0] c);
      key_pressed = kp; row_idx = r; col_idx = c;
      @(posedge clk);
      model_clock(kp, r, c);
      #1;
      check("model", {key_valid, key_strobe, key_held, key_code}, {e_valid, e_strobe, e_held, e_code});
      if (key_valid) n_valids++;
      if (key_strobe) n_strobes++;
   endtask

   task automatic idle_cycles(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 4'b0000, 4'b0000);
   endtask

   task automatic press_accept(input logic [3:0] r, input logic [3:0] c, input logic [3:0] code, input string name);
      for (int i = 0; i <= D; i++) begin
         step(1'b1, r, c);
         check(name, key_strobe, (i == D));
      end
      check(name, key_code, code);
   endtask

   initial begin
      int v0, s0, len, gap, rr, cc;
      logic [3:0] r, c;

      lut[0]  = 4'h1; lut[1]  = 4'h2; lut[2]  = 4'h3; lut[3]  = 4'hA;
      lut[4]  = 4'h4; lut[5]  = 4'h5; lut[6]  = 4'h6; lut[7]  = 4'hB;
      lut[8]  = 4'h7; lut[9]  = 4'h8; lut[10] = 4'h9; lut[11] = 4'hC;
      lut[12] = 4'hE; lut[13] = 4'h0; lut[14] = 4'hF; lut[15] = 4'hD;
      for (int i = 0; i < 16; i++)
         vec[i] = '{oh(i / 4), oh(i % 4), 1'b1, 4'h0};
      vec[0].code  = 4'h1; vec[1].code  = 4'h2; vec[2].code  = 4'h3; vec[3].code  = 4'hA;
      vec[4].code  = 4'h4; vec[5].code  = 4'h5; vec[6].code  = 4'h6; vec[7].code  = 4'hB;
      vec[8].code  = 4'h7; vec[9].code  = 4'h8; vec[10].code = 4'h9; vec[11].code = 4'hC;
      vec[12].code = 4'hE; vec[13].code = 4'h0; vec[14].code = 4'hF; vec[15].code = 4'hD;
      vec[16] = '{4'b0011, 4'b0001, 1'b0, 4'hD};
      vec[17] = '{4'b0001, 4'b0000, 1'b0, 4'hD};
      vec[18] = '{4'b0000, 4'b0000, 1'b0, 4'hD};

      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {key_valid, key_strobe, key_held, key_code}, 7'h0);
      rst_n = 1'b1;
      idle_cycles(2);

      // Clean press r0/c1 held 20 cycles
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 4'b0001, 4'b0010);
         check("clean_strobe", key_strobe, (i == D));
         check("clean_valid", key_valid, (i == D));
      end
      check("clean_code", key_code, 4'h2);
      check("clean_held", key_held, 1'b1);

      // Same key re-detected every 10 cycles: valid per rise, no new strobes
      v0 = n_valids; s0 = n_strobes;
      for (int p = 0; p < 6; p++) begin
         step(1'b0, 4'b0001, 4'b0010);
         repeat (9) step(1'b1, 4'b0001, 4'b0010);
      end
      check("hold_valids", n_valids - v0, 6);
      check("hold_strobes", n_strobes - s0, 0);
      check("hold_held", key_held, 1'b1);

      // Release: last matching rise was 9 steps ago, held falls 16 after it
      for (int k = 1; k <= 10; k++) begin
         step(1'b0, 4'b0001, 4'b0010);
         check("release_held", key_held, (k < 8));
      end
      press_accept(4'b1000, 4'b0010, 4'h0, "r3c1_press");
      idle_cycles(R + 1);
      check("r3c1_released", key_held, 1'b0);

      // Bounce abort after 3 stable cycles
      s0 = n_strobes;
      repeat (3) step(1'b1, 4'b0010, 4'b0001);
      step(1'b0, 4'b0010, 4'b0001);
      check("bounce_valid", key_valid, 1'b1);
      check("bounce_code", key_code, 4'h0);
      check("bounce_strobes", n_strobes - s0, 0);
      check("bounce_held", key_held, 1'b0);
      idle_cycles(2);
      press_accept(4'b0100, 4'b0100, 4'h9, "after_bounce");
      idle_cycles(R + 1);

      // Second key while HELD, then a non-matching rise exactly on the timeout cycle
      press_accept(4'b0001, 4'b0001, 4'h1, "first_key");
      idle_cycles(2);
      step(1'b1, 4'b0001, 4'b0100);
      check("second_valid", key_valid, 1'b1);
      check("second_strobe", key_strobe, 1'b0);
      check("second_code", key_code, 4'h1);
      check("second_held", key_held, 1'b1);
      idle_cycles(1 + (R - 5));
      step(1'b1, 4'b0010, 4'b0010);
      check("timeout_rise_valid", key_valid, 1'b1);
      check("timeout_rise_held", key_held, 1'b0);
      idle_cycles(2);

      // Async reset while debouncing at count 5
      for (int i = 0; i < 6; i++) step(1'b1, 4'b0001, 4'b1000);
      rst_n = 1'b0; key_pressed = 1'b0;
      #1;
      check("async_reset", {key_valid, key_strobe, key_held, key_code}, 7'h0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      v0 = n_valids;
      idle_cycles(10);
      check("post_reset_valids", n_valids - v0, 0);
      press_accept(4'b0001, 4'b1000, 4'hA, "post_reset_press");
      idle_cycles(R + 1);

      // Decode table plus malformed-index rises
      for (int i = 0; i < 19; i++) begin
         step(1'b0, 4'b0000, 4'b0000);
         s0 = n_strobes;
         for (int k = 0; k <= D; k++) begin
            step(1'b1, vec[i].row, vec[i].col);
            if (vec[i].ok && k == D) check("tbl_strobe", key_strobe, 1'b1);
            if (!vec[i].ok && k == 0) check("tbl_bad_valid", key_valid, 1'b1);
         end
         check("tbl_code", key_code, vec[i].code);
         check("tbl_strobe_count", n_strobes - s0, vec[i].ok ? 1 : 0);
         idle_cycles(R + 1);
      end

      // Randomized presses with bounces and index changes
      for (int n = 0; n < 3000; n += len + gap) begin
         len = $urandom_range(1, 24);
         gap = $urandom_range(1, 20);
         rr = $urandom_range(0, 1);
         cc = $urandom_range(0, 3);
         r = oh(rr); c = oh(cc);
         for (int k = 0; k < len; k++) begin
            if ($urandom_range(0, 15) == 0) c = oh($urandom_range(0, 3));
            step(1'b1, r, c);
         end
         for (int k = 0; k < gap; k++) step(1'b0, r, c);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/keypad_debouncer.md
Name: keypad_debouncer

Overview:
- Handshake partner of the row-scanning keypad scanner.
- Consumes the scanner's key_pressed, row_idx and col_idx, and returns key_valid, which releases the scanner's row hold.
- Debounces the press by requiring a stable match for a fixed time, emits one hex key code per physical press, and rejects auto-repeat by waiting for a debounced release.
- Sits between the scanner and the display/key-history logic.

Parameters:
- DEBOUNCE_CYCLES, 60000, consecutive matching cycles required to accept a press (20 ms @ 3 MHz).
- RELEASE_CYCLES, 30000, cycles with no matching re-detection before a held key counts as released; must exceed 4 scan periods (24000).
- CNT_W, 32, width of the internal counters.

Ports:
- clk  input  1  system clock (3 MHz).
- rst_n  input  1  asynchronous active-low reset.
- key_pressed  input  1  scanner: exactly one column low on the active row.
- row_idx  input  4  scanner: one-hot active row.
- col_idx  input  4  scanner: one-hot pressed column.
- key_valid  output  1  one-cycle pulse; tells the scanner to resume scanning.
- key_strobe  output  1  one-cycle pulse; a new debounced key has been accepted.
- key_code  output  4  hex code of the last accepted key; holds its value between strobes.
- key_held  output  1  high while in HELD.

Behaviour:
- Reset (async, rst_n=0): key_valid=0, key_strobe=0, key_code=4'h0, key_held=0, state IDLE, both counters 0, kp_d=0.
- Edge detect: kp_d registers key_pressed. rise = key_pressed & ~kp_d. The FSM acts only on rise, never on level. This prevents stale key_pressed highs after a key_valid from being taken as new detections.
- match = key_pressed & (row_idx == cap_row) & (col_idx == cap_col).
- Indices that are not one-hot on rise: treat as a mismatch. Pulse key_valid and stay in or return to IDLE.
- IDLE:
  - On rise with valid indices: capture cap_row/cap_col, deb_cnt=0, go to DEBOUNCE.
- DEBOUNCE:
  - match and deb_cnt < DEBOUNCE_CYCLES-1: deb_cnt++.
  - match and deb_cnt == DEBOUNCE_CYCLES-1: next cycle key_valid=1, key_strobe=1, key_code=decode(cap), key_held=1; rel_cnt=0; go to HELD.
  - !match (bounce or index change): abort. Next cycle key_valid=1, key_strobe=0, key_code unchanged; go to IDLE.
  - Net latency: the strobe is asserted exactly DEBOUNCE_CYCLES clocks after the rise cycle.
- HELD:
  - rel_cnt++ every cycle.
  - On rise: key_valid pulses the next cycle. Matching indices reset rel_cnt to 0. Non-matching indices (a second key) are ignored, with no strobe.
  - rel_cnt == RELEASE_CYCLES-1 with no rise that cycle: go to IDLE, key_held=0.
  - Simultaneous rise and timeout:
    - Matching rise wins: stay in HELD, rel_cnt=0.
    - Non-matching rise: go to IDLE and still pulse key_valid.
- key_valid rules:
  - Always registered; exactly one pulse per rise.
  - Never two consecutive cycles high.
  - Never asserted without a preceding rise, so the scanner never deadlocks holding a row.
- Decode, row r / col c to key_code:
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: E,0,F,D
- Counters saturate and never wrap. Compare with == against the parameters sized to CNT_W.
- Reset mid-operation: immediate return to reset values; no pulse is emitted on deassertion.

Test Plan (DEBOUNCE_CYCLES=8, RELEASE_CYCLES=16):
- Clean press: rise with row_idx=0001, col_idx=0010, held stable 20 cycles -> key_strobe and key_valid high for 1 cycle exactly 8 clocks after the rise; key_code=4'h2; key_held=1.
- Bounce abort: press stable 3 cycles, then key_pressed=0 -> key_valid pulse the next cycle, no key_strobe, key_code unchanged, state IDLE; a later clean press still accepted.
- Hold/no-repeat: after accept, the same row/col re-rises every 10 cycles for 60 cycles -> a key_valid pulse per rise, zero extra strobes, key_held stays 1.
- Release: re-detections stop -> key_held falls 16 clocks after the last matching rise; the next press of row 3/col 1 strobes key_code=4'h0.
- Second key while HELD: rise with a different col -> key_valid pulse, no strobe, key_code unchanged. Also drive a non-matching rise on the timeout cycle -> IDLE plus key_valid pulse.
- Async reset in DEBOUNCE at count 5 -> all outputs 0 immediately; no key_valid after rst_n rises until a new rise arrives.
